// File: rtl/dmux_rr_ctrl_if.sv
// Handshake and data bus between a word source, the round-robin controller and N channels.
// slave = controller side, master = source/sink side.
interface dmux_rr_ctrl_if #(
  parameter int N     = 2,
  parameter int WIDTH = 1,
  parameter int SW    = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SW-1:0]    out_sel;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic             busy;

  modport slave (
    input  en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, busy
  );

  modport master (
    output en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, busy
  );
endinterface

// File: rtl/dmux_rr_ctrl.sv
// Round-robin word scheduler: one input stream spread over N channels, BURST words per channel.
// Accept-to-out_valid latency 1 cycle; one word in flight, so at most one word every 2 cycles.
module dmux_rr_ctrl #(
  parameter int N     = 2,
  parameter int WIDTH = 1,
  parameter int BURST = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmux_rr_ctrl_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [SW-1:0]    ptr;
  logic [7:0]       burst_cnt;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_sel_q;
  logic [N-1:0]     out_valid_q;

  logic [SW-1:0]    dest;
  logic [N-1:0]     dest_onehot;
  logic             accept;

  // First enabled channel at or after ptr, wrapping explicitly so odd N never overruns.
  always_comb begin : search
    int   p;
    logic found;
    p     = 0;
    found = 1'b0;
    dest  = '0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!found && bus.en[SW'(p)]) begin
        dest  = SW'(p);
        found = 1'b1;
      end
    end
    dest_onehot       = '0;
    dest_onehot[dest] = 1'b1;
  end

  // Gated by rst so the source never sees ready while the block is held in reset.
  assign bus.in_ready = (state == IDLE) && (bus.en != '0) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      burst_cnt   <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_data_q  <= bus.in_data;
            out_sel_q   <= dest;
            out_valid_q <= dest_onehot;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Destination is locked; only the addressed channel's ready matters.
          if (bus.out_ready[out_sel_q]) begin
            out_valid_q <= '0;
            state       <= IDLE;
            if (burst_cnt == 8'(BURST - 1)) begin
              burst_cnt <= '0;
              ptr       <= (out_sel_q == SW'(N - 1)) ? '0 : out_sel_q + 1'b1;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
              ptr       <= out_sel_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == HOLD);
endmodule

// File: tb/tb_dmux_rr_ctrl.sv
// Directed bench for dmux_rr_ctrl: table of words with expected channels plus hand sequences.
// Instances: A (N=4,BURST=1), B (N=2,BURST=1), C (N=3,BURST=3), all WIDTH=4.
module tb_dmux_rr_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmux_rr_ctrl_if #(.N(4), .WIDTH(4)) ifa ();
  dmux_rr_ctrl_if #(.N(2), .WIDTH(4)) ifb ();
  dmux_rr_ctrl_if #(.N(3), .WIDTH(4)) ifc ();

  dmux_rr_ctrl #(.N(4), .WIDTH(4), .BURST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmux_rr_ctrl #(.N(2), .WIDTH(4), .BURST(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  dmux_rr_ctrl #(.N(3), .WIDTH(4), .BURST(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         do_rst;
    int         d;
    logic [3:0] en;
    logic [3:0] data;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  task automatic drv(input int d, input logic [3:0] en, input logic v, input logic [3:0] dat);
    case (d)
      0: begin ifa.en = en;      ifa.in_valid = v; ifa.in_data = dat; end
      1: begin ifb.en = en[1:0]; ifb.in_valid = v; ifb.in_data = dat; end
      default: begin ifc.en = en[2:0]; ifc.in_valid = v; ifc.in_data = dat; end
    endcase
  endtask

  task automatic smp(input int d, output logic [3:0] ov, output logic [1:0] sel,
                     output logic [3:0] od, output logic ir, output logic bz);
    case (d)
      0: begin ov = ifa.out_valid; sel = ifa.out_sel; od = ifa.out_data;
               ir = ifa.in_ready; bz = ifa.busy; end
      1: begin ov = {2'b00, ifb.out_valid}; sel = {1'b0, ifb.out_sel}; od = ifb.out_data;
               ir = ifb.in_ready; bz = ifb.busy; end
      default: begin ov = {1'b0, ifc.out_valid}; sel = ifc.out_sel; od = ifc.out_data;
               ir = ifc.in_ready; bz = ifc.busy; end
    endcase
  endtask

  task automatic do_reset();
    drv(0, 4'h0, 1'b0, 4'h0);
    drv(1, 4'h0, 1'b0, 4'h0);
    drv(2, 4'h0, 1'b0, 4'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Called from IDLE; presents one word and checks the HOLD cycle that follows.
  task automatic send(input int d, input logic [3:0] en, input logic [3:0] data,
                      input logic [1:0] sel, input string nm);
    logic [3:0] ov, od;
    logic [1:0] s;
    logic ir, bz;
    drv(d, en, 1'b1, data);
    #1 smp(d, ov, s, od, ir, bz);
    chk({nm, ".in_ready_idle"}, 32'(ir), 32'd1);
    @(posedge clk); #1;
    drv(d, en, 1'b0, 4'h0);
    smp(d, ov, s, od, ir, bz);
    chk({nm, ".out_valid"}, 32'(ov), 32'(oh(sel)));
    chk({nm, ".out_sel"},   32'(s),  32'(sel));
    chk({nm, ".out_data"},  32'(od), 32'(data));
    chk({nm, ".in_ready_hold"}, 32'(ir), 32'd0);
    chk({nm, ".busy"},      32'(bz), 32'd1);
  endtask

  task automatic expect_idle(input int d, input string nm);
    logic [3:0] ov, od;
    logic [1:0] s;
    logic ir, bz;
    smp(d, ov, s, od, ir, bz);
    chk({nm, ".out_valid_clr"}, 32'(ov), 32'd0);
    chk({nm, ".busy_clr"},      32'(bz), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    ifa.out_ready = 4'hF;
    ifb.out_ready = 2'b11;
    ifc.out_ready = 3'b111;
    drv(0, 4'hF, 1'b0, 4'h0);
    drv(1, 4'h3, 1'b0, 4'h0);
    drv(2, 4'h7, 1'b0, 4'h0);

    // Reset values, with en nonzero so in_ready gating is exercised.
    #2 rst = 1'b1;
    #1;
    chk("rst.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst.out_sel",   32'(ifa.out_sel),   32'd0);
    chk("rst.out_data",  32'(ifa.out_data),  32'd0);
    chk("rst.in_ready",  32'(ifa.in_ready),  32'd0);
    chk("rst.busy",      32'(ifa.busy),      32'd0);
    @(posedge clk); #1 rst = 1'b0;

    tbl[0]  = '{1, 0, 4'hF, 4'hA, 2'd0};
    tbl[1]  = '{0, 0, 4'hF, 4'hB, 2'd1};
    tbl[2]  = '{0, 0, 4'hF, 4'hC, 2'd2};
    tbl[3]  = '{0, 0, 4'hF, 4'hD, 2'd3};
    tbl[4]  = '{0, 0, 4'hF, 4'hE, 2'd0};
    tbl[5]  = '{0, 0, 4'hA, 4'h1, 2'd1};
    tbl[6]  = '{0, 0, 4'hA, 4'h2, 2'd3};
    tbl[7]  = '{0, 0, 4'hA, 4'h3, 2'd1};
    tbl[8]  = '{0, 0, 4'hA, 4'h4, 2'd3};
    tbl[9]  = '{0, 0, 4'hA, 4'h5, 2'd1};
    tbl[10] = '{1, 2, 4'h7, 4'h1, 2'd0};
    tbl[11] = '{0, 2, 4'h7, 4'h2, 2'd0};
    tbl[12] = '{0, 2, 4'h7, 4'h3, 2'd0};
    tbl[13] = '{0, 2, 4'h7, 4'h4, 2'd1};
    tbl[14] = '{0, 2, 4'h7, 4'h5, 2'd1};
    tbl[15] = '{0, 2, 4'h7, 4'h6, 2'd1};
    tbl[16] = '{0, 2, 4'h7, 4'h7, 2'd2};
    tbl[17] = '{0, 2, 4'h7, 4'h8, 2'd2};
    tbl[18] = '{0, 2, 4'h7, 4'h9, 2'd2};
    tbl[19] = '{1, 2, 4'h7, 4'h1, 2'd0};
    tbl[20] = '{0, 2, 4'h7, 4'h2, 2'd0};
    tbl[21] = '{0, 2, 4'h7, 4'h3, 2'd0};
    tbl[22] = '{0, 2, 4'h7, 4'h4, 2'd1};
    tbl[23] = '{0, 2, 4'h5, 4'h5, 2'd2};
    tbl[24] = '{0, 2, 4'h5, 4'h6, 2'd2};
    tbl[25] = '{0, 2, 4'h5, 4'h7, 2'd0};

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].do_rst) do_reset();
      send(tbl[i].d, tbl[i].en, tbl[i].data, tbl[i].sel, $sformatf("vec%0d", i));
      @(posedge clk); #1;
      expect_idle(tbl[i].d, $sformatf("vec%0d", i));
    end

    // No eligible channel: valid held high, nothing accepted.
    drv(0, 4'h0, 1'b1, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("en0.in_ready%0d", i),  32'(ifa.in_ready),  32'd0);
      chk($sformatf("en0.out_valid%0d", i), 32'(ifa.out_valid), 32'd0);
    end
    drv(0, 4'h0, 1'b0, 4'h0);

    // Asynchronous reset while a word waits on channel 1.
    do_reset();
    ifb.out_ready = 2'b01;
    send(1, 4'h3, 4'h3, 2'd0, "ar.w0");
    @(posedge clk); #1;
    ifb.out_ready = 2'b00;
    send(1, 4'h3, 4'h4, 2'd1, "ar.w1");
    #3 rst = 1'b1;
    #1;
    chk("ar.out_valid", 32'(ifb.out_valid), 32'd0);
    chk("ar.busy",      32'(ifb.busy),      32'd0);
    chk("ar.out_sel",   32'(ifb.out_sel),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("ar.in_ready_after", 32'(ifb.in_ready), 32'd1);
    ifb.out_ready = 2'b11;
    send(1, 4'h3, 4'h5, 2'd0, "ar.w2");
    @(posedge clk); #1;
    expect_idle(1, "ar.w2");

    // Back-pressure on channel 0; ready on channel 1 must not complete it.
    do_reset();
    ifb.out_ready = 2'b10;
    send(1, 4'h3, 4'h1, 2'd0, "bp.w0");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.out_valid%0d", i), 32'(ifb.out_valid), 32'd1);
      chk($sformatf("bp.out_data%0d", i),  32'(ifb.out_data),  32'd1);
      chk($sformatf("bp.in_ready%0d", i),  32'(ifb.in_ready),  32'd0);
    end
    ifb.out_ready = 2'b11;
    @(posedge clk); #1;
    expect_idle(1, "bp.w0");
    chk("bp.in_ready_idle", 32'(ifb.in_ready), 32'd1);
    send(1, 4'h3, 4'h2, 2'd1, "bp.w1");
    @(posedge clk); #1;
    expect_idle(1, "bp.w1");

    // Destination stays locked when its enable drops during HOLD.
    do_reset();
    ifc.out_ready = 3'b000;
    send(2, 4'h4, 4'h6, 2'd2, "lk");
    drv(2, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lk.out_valid%0d", i), 32'(ifc.out_valid), 32'h4);
      chk($sformatf("lk.out_sel%0d", i),   32'(ifc.out_sel),   32'd2);
      chk($sformatf("lk.out_data%0d", i),  32'(ifc.out_data),  32'h6);
    end
    ifc.out_ready = 3'b100;
    @(posedge clk); #1;
    expect_idle(2, "lk");
    chk("lk.in_ready_en0", 32'(ifc.in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
